// File: rtl/quant_coeff_writer_pkg.sv
// quant_ctrl_pkg: shared FSM states and ctrl_reg bit positions for quant_coeff_writer.
package quant_ctrl_pkg;
    typedef enum logic [2:0] {PRIME, IDLE, SETTLE, CHECK, WAIT_SYNC, WRITE} state_t;
    localparam int CTRL_TOG     = 0;
    localparam int CTRL_FILL    = 1;
    localparam int CTRL_ERRCLR  = 3;
    localparam int CTRL_LEN_LSB = 16;
endpackage

// File: rtl/quant_coeff_writer_if.sv
// quant_coeff_writer_if: coefficient BRAM write port.
interface quant_coeff_writer_if #(parameter int ADDR_W = 10, parameter int DATA_W = 18);
    logic              coeff_we;
    logic [ADDR_W-1:0] coeff_addr;
    logic [DATA_W-1:0] coeff_din;
    modport master(output coeff_we, coeff_addr, coeff_din);
    modport slave(input coeff_we, coeff_addr, coeff_din);
endinterface

// File: rtl/quant_coeff_writer_addr_gen.sv
// quant_coeff_addr_gen: loadable wrapping address counter with remaining-write down-counter.
module quant_coeff_addr_gen #(parameter int ADDR_W = 10) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [15:0]       len_in,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    logic [15:0] rem;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            addr <= '0;
            rem  <= '0;
        end else if (load) begin
            addr <= addr_in;
            rem  <= len_in;
        end else if (step) begin
            addr <= addr + 1'b1;
            rem  <= rem - 1'b1;
        end
    assign last = rem == 16'd1;
endmodule

// File: rtl/quant_coeff_writer.sv
// quant_coeff_writer: toggle-triggered coefficient BRAM writer (single write or burst fill).
// Optional QUANT_SYNC_GATE_EN holds each write/burst until a sync_in pulse.
module quant_coeff_writer
    import quant_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 18,
    parameter int SETTLE_CYC = 4
) (
    input  logic                 user_clk,
    input  logic                 user_rst,
    input  logic [31:0]          addr_reg,
    input  logic [31:0]          data_reg,
    input  logic [31:0]          ctrl_reg,
`ifdef QUANT_SYNC_GATE_EN
    input  logic                 sync_in,
`endif
    quant_coeff_writer_if.master bram,
    output logic                 busy,
    output logic [15:0]          wr_count,
    output logic                 err
);
    state_t            state;
    logic              tog_q;
    logic [15:0]       cnt;
    logic [31:0]       a;
    logic [DATA_W-1:0] d;
    logic              fill;
    logic [15:0]       len;
    logic              addr_err, len_err, load, step, last;
    logic              unused;
    assign addr_err = (a >> ADDR_W) != 32'd0;
    assign len_err  = fill && len == 16'd0;
    assign load     = state == CHECK && !addr_err && !len_err;
    assign step     = state == WRITE && !last;
    assign unused   = ^{ctrl_reg, data_reg};
    quant_coeff_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk     (user_clk),
        .rst     (user_rst),
        .load    (load),
        .step    (step),
        .addr_in (a[ADDR_W-1:0]),
        .len_in  (fill ? len : 16'd1),
        .addr    (bram.coeff_addr),
        .last    (last)
    );
    always_ff @(posedge user_clk or posedge user_rst)
        if (user_rst) begin
            state          <= PRIME;
            tog_q          <= 1'b0;
            cnt            <= '0;
            a              <= '0;
            d              <= '0;
            fill           <= 1'b0;
            len            <= '0;
            bram.coeff_we  <= 1'b0;
            bram.coeff_din <= '0;
            busy           <= 1'b0;
            wr_count       <= '0;
            err            <= 1'b0;
        end else begin
            wr_count <= wr_count + 16'(bram.coeff_we);
            // a fresh error beats a simultaneous clear
            err <= (state == CHECK && (addr_err || len_err)) || (err && !ctrl_reg[CTRL_ERRCLR]);
            case (state)
                PRIME: begin
                    tog_q <= ctrl_reg[CTRL_TOG];
                    state <= IDLE;
                end
                IDLE: if (ctrl_reg[CTRL_TOG] != tog_q) begin
                    tog_q <= ctrl_reg[CTRL_TOG];
                    cnt   <= 16'(SETTLE_CYC - 1);
                    busy  <= 1'b1;
                    state <= SETTLE;
                end
                SETTLE: if (cnt == 16'd0) begin
                    a     <= addr_reg;
                    d     <= data_reg[DATA_W-1:0];
                    fill  <= ctrl_reg[CTRL_FILL];
                    len   <= ctrl_reg[CTRL_LEN_LSB +: 16];
                    state <= CHECK;
                end else cnt <= cnt - 16'd1;
                CHECK: if (!load) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    bram.coeff_din <= d;
`ifdef QUANT_SYNC_GATE_EN
                    state <= WAIT_SYNC;
`else
                    bram.coeff_we <= 1'b1;
                    state <= WRITE;
`endif
                end
`ifdef QUANT_SYNC_GATE_EN
                WAIT_SYNC: if (sync_in) begin
                    bram.coeff_we <= 1'b1;
                    state <= WRITE;
                end
`endif
                WRITE: if (last) begin
                    bram.coeff_we <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_quant_coeff_writer.sv
// tb_quant_coeff_writer: scoreboard bench; expected BRAM writes queued by stimulus, checked by a monitor.
module tb_quant_coeff_writer;
    typedef struct {logic [9:0] addr; logic [17:0] din;} wr_t;
    logic clk = 0, rst;
    logic [31:0] addr_reg, data_reg, ctrl_reg;
    logic busy, err;
    logic [15:0] wr_count;
    logic tog;
    int errors = 0, checks = 0;
    wr_t exp_q[$];
    wr_t e_m;
    quant_coeff_writer_if #(.ADDR_W(10), .DATA_W(18)) bus ();
`ifdef QUANT_SYNC_GATE_EN
    logic sync_in;
    initial begin
        sync_in = 0;
        forever begin
            repeat (3) @(posedge clk);
            #1 sync_in = 1;
            @(posedge clk);
            #1 sync_in = 0;
        end
    end
`endif
    quant_coeff_writer #(.ADDR_W(10), .DATA_W(18), .SETTLE_CYC(4)) dut (
        .user_clk (clk),
        .user_rst (rst),
        .addr_reg (addr_reg),
        .data_reg (data_reg),
        .ctrl_reg (ctrl_reg),
`ifdef QUANT_SYNC_GATE_EN
        .sync_in  (sync_in),
`endif
        .bram     (bus),
        .busy     (busy),
        .wr_count (wr_count),
        .err      (err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [9:0] ad, input logic [17:0] dn);
        exp_q.push_back('{addr: ad, din: dn});
    endtask
    task automatic drive(input logic [31:0] ad, input logic [31:0] dt, input bit fl,
                         input logic [15:0] ln, input bit clr, input bit flip);
        if (flip) tog = ~tog;
        addr_reg = ad;
        data_reg = dt;
        ctrl_reg = {ln, 12'h0, clr, 1'b0, fl, tog};
    endtask
    task automatic wait_idle;
        int n = 0;
        tick;
        while ((busy || bus.coeff_we) && n < 300) begin
            tick;
            n++;
        end
        chk("idle_timeout", 32'(busy), 0);
    endtask
    task automatic wait_we;
        int n = 0;
        while (!bus.coeff_we && n < 100) begin
            tick;
            n++;
        end
        chk("we_timeout", 32'(bus.coeff_we), 1);
    endtask
    always @(negedge clk)
        if (!rst && bus.coeff_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%0h din=%0h expected none", bus.coeff_addr, bus.coeff_din);
            end else begin
                e_m = exp_q.pop_front();
                chk("wr_addr", 32'(bus.coeff_addr), 32'(e_m.addr));
                chk("wr_din", 32'(bus.coeff_din), 32'(e_m.din));
            end
        end
    initial begin
        int n;
        rst = 1; tog = 0;
        addr_reg = 0; data_reg = 0; ctrl_reg = 0;
        repeat (3) tick;
        chk("rst_we", 32'(bus.coeff_we), 0);
        chk("rst_addr", 32'(bus.coeff_addr), 0);
        chk("rst_din", 32'(bus.coeff_din), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(wr_count), 0);
        chk("rst_err", 32'(err), 0);
        rst = 0;
        repeat (2) tick;
        chk("idle_busy", 32'(busy), 0);
        // single write with exact latency
        push(10'h005, 18'h01234);
        drive(32'h5, 32'h1234, 0, 0, 0, 1);
`ifndef QUANT_SYNC_GATE_EN
        tick;
        chk("t1_busy_rise", 32'(busy), 1);
        repeat (4) tick;
        chk("t1_we_early", 32'(bus.coeff_we), 0);
        tick;
        chk("t1_we_on", 32'(bus.coeff_we), 1);
        chk("t1_busy_hold", 32'(busy), 1);
        tick;
        chk("t1_we_off", 32'(bus.coeff_we), 0);
        chk("t1_busy_fall", 32'(busy), 0);
`else
        wait_idle;
`endif
        chk("t1_count", 32'(wr_count), 1);
        // fill across the address wrap
        push(10'h3FE, 18'h2AAAA); push(10'h3FF, 18'h2AAAA);
        push(10'h000, 18'h2AAAA); push(10'h001, 18'h2AAAA);
        drive(32'h3FE, 32'h2AAAA, 1, 4, 0, 1);
        wait_idle;
        chk("t2_count", 32'(wr_count), 5);
        // address out of range
        drive(32'h400, 32'h111, 0, 0, 0, 1);
        wait_idle;
        chk("t3_err", 32'(err), 1);
        chk("t3_count", 32'(wr_count), 5);
        drive(32'h400, 32'h111, 0, 0, 1, 0);
        tick;
        drive(32'h400, 32'h111, 0, 0, 0, 0);
        tick;
        chk("t3_clear", 32'(err), 0);
        // zero-length fill, then set against clear
        drive(32'h10, 32'h5, 1, 0, 0, 1);
        wait_idle;
        chk("t4_err", 32'(err), 1);
        drive(32'h10, 32'h5, 1, 0, 1, 0);
        tick;
        chk("t4_clear", 32'(err), 0);
        drive(32'h10, 32'h5, 1, 0, 1, 1);
        tick;
        chk("t4_clr_held", 32'(err), 0);
        repeat (5) tick;
        chk("t4_set_wins", 32'(err), 1);
        drive(32'h10, 32'h5, 1, 0, 0, 0);
        tick;
        chk("t4_sticky", 32'(err), 1);
        chk("t4_count", 32'(wr_count), 5);
        // two toggles during a burst cancel
        for (int i = 0; i < 16; i++) push(10'(32'h100 + i), 18'h3FFFF);
        drive(32'h100, 32'h3FFFF, 1, 16, 0, 1);
        tick;
        wait_we;
        drive(32'h100, 32'h3FFFF, 1, 16, 0, 1);
        tick;
        drive(32'h100, 32'h3FFFF, 1, 16, 0, 1);
        wait_idle;
        repeat (3) tick;
        chk("t5_no_cmd", 32'(busy), 0);
        chk("t5_count", 32'(wr_count), 21);
        // one toggle during a burst is serviced right after it
        for (int i = 0; i < 16; i++) push(10'(32'h100 + i), 18'h3FFFF);
        push(10'h200, 18'h7);
        drive(32'h100, 32'h3FFFF, 1, 16, 0, 1);
        tick;
        wait_we;
        drive(32'h200, 32'h7, 0, 0, 0, 1);
        n = 0;
        tick;
        while (busy && n < 200) begin
            tick;
            n++;
        end
        chk("t5_fall_timeout", 32'(busy), 0);
        tick;
        chk("t5_restart", 32'(busy), 1);
        wait_idle;
        chk("t5_count2", 32'(wr_count), 38);
        // reset mid-fill
        push(10'h020, 18'h155); push(10'h021, 18'h155); push(10'h022, 18'h155);
        drive(32'h20, 32'h155, 1, 8, 0, 1);
        tick;
        wait_we;
        repeat (2) tick;
        @(negedge clk);
        #1 rst = 1;
        #1;
        chk("t6_we_async", 32'(bus.coeff_we), 0);
        chk("t6_count", 32'(wr_count), 0);
        chk("t6_busy", 32'(busy), 0);
        tog = 1;
        drive(32'h33, 32'h9, 0, 0, 0, 0);
        repeat (2) tick;
        rst = 0;
        repeat (10) tick;
        chk("t6_no_cmd", 32'(busy), 0);
        chk("t6_no_write", 32'(wr_count), 0);
        push(10'h033, 18'h9);
        drive(32'h33, 32'h9, 0, 0, 0, 1);
        wait_idle;
        chk("t6_count_after", 32'(wr_count), 1);
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
